// File: rtl/vram_write_queue.sv
// vram_write_queue: buffers CPU-side VRAM writes in a FIFO. The FIFO drains into the
// GPU VRAM port at one entry per clock, and only while the GPU reports vblank.
// Each popped entry gives a one-cycle vram_write strobe on the cycle after the pop.
// Optional status ports (overflow, occupancy, clr_overflow) are built in when
// VRAM_WRITE_QUEUE_STATUS_EN is defined.
module vram_write_queue #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk_12_5875,
    input  logic                  rst_n,
    input  logic [7:0]            cpu_data,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic                  cpu_write,
    output logic                  cpu_ready,
    input  logic                  in_vblank,
    output logic [7:0]            vram_data,
    output logic [ADDR_WIDTH-1:0] vram_address,
    output logic                  vram_write,
`ifdef VRAM_WRITE_QUEUE_STATUS_EN
    input  logic                  clr_overflow,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   occupancy,
`endif
    output logic                  queue_empty
);

    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned ENTRY_W = ADDR_WIDTH + 8;

    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    typedef enum logic [0:0] {
        StIdle,
        StDrain
    } state_e;

    state_e state_q, state_d;

    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;

    logic [7:0]            vram_data_q, vram_data_d;
    logic [ADDR_WIDTH-1:0] vram_address_q, vram_address_d;
    logic                  vram_write_q, vram_write_d;

    logic                  push;
    logic                  pop;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    head;

    // Ready depends only on the registered count. A pop on the same edge does not
    // free a slot for the push on that edge.
    assign cpu_ready  = (count_q != FULL_COUNT);
    assign fifo_empty = (count_q == '0);
    assign push       = cpu_write & cpu_ready;
    assign head       = mem[rd_ptr_q];

    // Drain FSM: decides whether the head entry is popped on this edge.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                // The entry edge also pops. A vblank window of N edges then gives
                // N strobes.
                if (in_vblank && !fifo_empty) begin
                    state_d = StDrain;
                    pop     = 1'b1;
                end
            end
            StDrain: begin
                if (in_vblank && !fifo_empty) begin
                    pop = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next-state logic for the FIFO pointers and the occupancy count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // VRAM port registers. They load on a pop and hold their value otherwise.
    always_comb begin
        vram_write_d   = pop;
        vram_data_d    = vram_data_q;
        vram_address_d = vram_address_q;
        if (pop) begin
            vram_data_d    = head[7:0];
            vram_address_d = head[ENTRY_W-1:8];
        end
    end

    // State registers.
    always_ff @(posedge clk_12_5875 or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            vram_data_q    <= '0;
            vram_address_q <= '0;
            vram_write_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            vram_data_q    <= vram_data_d;
            vram_address_q <= vram_address_d;
            vram_write_q   <= vram_write_d;
        end
    end

    // FIFO storage. It is not reset because the pointers alone define which
    // entries are valid.
    always_ff @(posedge clk_12_5875) begin
        if (push) begin
            mem[wr_ptr_q] <= {cpu_address, cpu_data};
        end
    end

    assign vram_data    = vram_data_q;
    assign vram_address = vram_address_q;
    assign vram_write   = vram_write_q;
    assign queue_empty  = fifo_empty & ~vram_write_q;

`ifdef VRAM_WRITE_QUEUE_STATUS_EN
    logic overflow_q, overflow_d;

    // Sticky overflow flag. A clear wins over a set on the same edge.
    always_comb begin
        overflow_d = overflow_q;
        if (clr_overflow) begin
            overflow_d = 1'b0;
        end else if (cpu_write && !cpu_ready) begin
            overflow_d = 1'b1;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk_12_5875 or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign occupancy = count_q;
`endif

endmodule

// File: tb/tb_vram_write_queue.sv
// Self-checking bench for vram_write_queue against a queue-based reference model.
module tb_vram_write_queue;

    logic        clk_12_5875;
    logic        rst_n;
    logic [7:0]  cpu_data;
    logic [11:0] cpu_address;
    logic        cpu_write;
    logic        cpu_ready;
    logic        in_vblank;
    logic [7:0]  vram_data;
    logic [11:0] vram_address;
    logic        vram_write;
    logic        queue_empty;
`ifdef VRAM_WRITE_QUEUE_STATUS_EN
    logic        clr_overflow;
    logic        overflow;
    logic [4:0]  occupancy;
`endif

    vram_write_queue #(
        .DEPTH_LOG2 (4),
        .ADDR_WIDTH (12)
    ) dut (
        .clk_12_5875  (clk_12_5875),
        .rst_n        (rst_n),
        .cpu_data     (cpu_data),
        .cpu_address  (cpu_address),
        .cpu_write    (cpu_write),
        .cpu_ready    (cpu_ready),
        .in_vblank    (in_vblank),
        .vram_data    (vram_data),
        .vram_address (vram_address),
        .vram_write   (vram_write),
`ifdef VRAM_WRITE_QUEUE_STATUS_EN
        .clr_overflow (clr_overflow),
        .overflow     (overflow),
        .occupancy    (occupancy),
`endif
        .queue_empty  (queue_empty)
    );

    initial clk_12_5875 = 1'b0;
    always #5 clk_12_5875 = ~clk_12_5875;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: the pending writes, plus what the VRAM port should show.
    logic [19:0] mq[$];
    logic        exp_we;
    logic [11:0] exp_addr;
    logic [7:0]  exp_data;
    logic        exp_ovf;
    logic        clr_req;

    // Observations of the DUT strobes, used by the directed checks.
    int          dut_strobes;
    logic [7:0]  last_803_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        exp_ovf  = 1'b0;
    endtask

    task automatic check_outputs();
        chk("vram_write", 32'(vram_write), 32'(exp_we));
        chk("vram_address", 32'(vram_address), 32'(exp_addr));
        chk("vram_data", 32'(vram_data), 32'(exp_data));
        chk("queue_empty", 32'(queue_empty), 32'((mq.size() == 0) && !exp_we));
        chk("cpu_ready", 32'(cpu_ready), 32'(mq.size() != 16));
`ifdef VRAM_WRITE_QUEUE_STATUS_EN
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        chk("occupancy", 32'(occupancy), 32'(mq.size()));
`endif
    endtask

    // One clock: drive the inputs, run the edge, update the model, then check at +1.
    task automatic cycle(input logic w, input logic [11:0] a, input logic [7:0] d,
                         input logic vb);
        logic        ready;
        logic [19:0] ent;
        cpu_write   = w;
        cpu_address = a;
        cpu_data    = d;
        in_vblank   = vb;
`ifdef VRAM_WRITE_QUEUE_STATUS_EN
        clr_overflow = clr_req;
`endif
        ready = (mq.size() != 16);
        chk("cpu_ready_pre", 32'(cpu_ready), 32'(ready));
        @(posedge clk_12_5875);
        if (vb && mq.size() > 0) begin
            ent      = mq.pop_front();
            exp_we   = 1'b1;
            exp_addr = ent[19:8];
            exp_data = ent[7:0];
        end else begin
            exp_we = 1'b0;
        end
        if (w && ready) mq.push_back({a, d});
        if (clr_req) exp_ovf = 1'b0;
        else if (w && !ready) exp_ovf = 1'b1;
        #1;
        check_outputs();
        if (vram_write === 1'b1) begin
            dut_strobes++;
            if (vram_address === 12'h803) last_803_data = vram_data;
        end
    endtask

    task automatic drain_all();
        int guard;
        guard = 0;
        while ((mq.size() != 0 || exp_we) && guard < 40) begin
            cycle(1'b0, 12'h0, 8'h0, 1'b1);
            guard++;
        end
        chk("drain_bounded", 32'(mq.size()), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        cpu_write     = 1'b0;
        cpu_address   = '0;
        cpu_data      = '0;
        in_vblank     = 1'b0;
        clr_req       = 1'b0;
        dut_strobes   = 0;
        last_803_data = '0;
`ifdef VRAM_WRITE_QUEUE_STATUS_EN
        clr_overflow = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk_12_5875);
        #1;
        rst_n = 1'b1;
        check_outputs();

        // Test 1: an asynchronous reset in the middle of a drain.
        for (int i = 0; i < 7; i++) cycle(1'b1, 12'(i + 16), 8'(i + 1), 1'b0);
        cycle(1'b0, 12'h0, 8'h0, 1'b1);
        cycle(1'b0, 12'h0, 8'h0, 1'b1);
        chk("t1_mid_drain_write", 32'(vram_write), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk_12_5875);
        #1;
        rst_n = 1'b1;
        dut_strobes = 0;
        for (int i = 0; i < 4; i++) cycle(1'b0, 12'h0, 8'h0, 1'b1);
        chk("t1_no_strobes_after_reset", 32'(dut_strobes), 32'd0);

        // Test 2: writes are held outside vblank, then drain in order.
        cycle(1'b1, 12'h000, 8'h0F, 1'b0);
        cycle(1'b1, 12'h001, 8'h0F, 1'b0);
        cycle(1'b1, 12'h800, 8'h0F, 1'b0);
        cycle(1'b0, 12'h0, 8'h0, 1'b0);
        dut_strobes = 0;
        drain_all();
        cycle(1'b0, 12'h0, 8'h0, 1'b1);
        chk("t2_strobes", 32'(dut_strobes), 32'd3);
        chk("t2_empty", 32'(queue_empty), 32'd1);

        // Test 3: fill the FIFO, reject the 17th push, then drain exactly 16 entries.
        for (int i = 0; i < 16; i++) cycle(1'b1, 12'(12'h100 + i), 8'($urandom), 1'b0);
        cycle(1'b1, 12'h1FF, 8'hAA, 1'b0);
`ifdef VRAM_WRITE_QUEUE_STATUS_EN
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_occupancy", 32'(occupancy), 32'd16);
        clr_req = 1'b1;
        cycle(1'b0, 12'h0, 8'h0, 1'b0);
        clr_req = 1'b0;
        chk("t3_overflow_cleared", 32'(overflow), 32'd0);
`endif
        dut_strobes = 0;
        drain_all();
        cycle(1'b0, 12'h0, 8'h0, 1'b1);
        chk("t3_strobes", 32'(dut_strobes), 32'd16);

        // Test 4: a short vblank window, with the rest drained at the next vblank.
        for (int i = 0; i < 8; i++) cycle(1'b1, 12'(12'h200 + i), 8'(8'h40 + i), 1'b0);
        dut_strobes = 0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 12'h0, 8'h0, 1'b1);
        cycle(1'b0, 12'h0, 8'h0, 1'b0);
        cycle(1'b0, 12'h0, 8'h0, 1'b0);
        chk("t4_window_strobes_ok", 32'(dut_strobes >= 3 && dut_strobes <= 4), 32'd1);
        dut_strobes = 0;
        drain_all();
        chk("t4_rest_strobes", 32'(dut_strobes), 32'd5);

        // Test 5: a push into a full FIFO on a pop edge is rejected; the next one is accepted.
        for (int i = 0; i < 16; i++) cycle(1'b1, 12'(12'h300 + i), 8'(i), 1'b0);
        cycle(1'b1, 12'h3AA, 8'hEE, 1'b1);
        chk("t5_ready_after_pop", 32'(cpu_ready), 32'd1);
        cycle(1'b1, 12'h3BB, 8'hDD, 1'b0);
        chk("t5_full_again", 32'(cpu_ready), 32'd0);
        drain_all();

        // Test 6: the last write to the same address lands last.
        cycle(1'b1, 12'h803, 8'h07, 1'b0);
        cycle(1'b1, 12'h803, 8'h03, 1'b0);
        drain_all();
        chk("t6_last_803", 32'(last_803_data), 32'h03);

        // Randomized traffic with bursty vblank windows.
        begin
            logic vb;
            vb = 1'b0;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 9) == 0) vb = ~vb;
`ifdef VRAM_WRITE_QUEUE_STATUS_EN
                clr_req = ($urandom_range(0, 19) == 0);
`endif
                cycle(($urandom_range(0, 99) < 55), 12'($urandom), 8'($urandom), vb);
            end
            clr_req = 1'b0;
            drain_all();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
